imem_loader: RTL
================

# imem_loader

Boot-time program loader that writes into the core's instruction memory. It takes a byte stream with a valid/ready handshake, decodes a 16-bit word-count header, assembles each group of four bytes into a 32-bit instruction word and issues one write per word to the instruction-memory write port. It holds the CPU in reset from power-up until a load completes successfully, so the core never fetches a partially loaded program.

## Interface
Parameters:
- DEPTH, 1024: instruction memory size in words; must be ≤ 65535.
- AW, 10: write address width; must satisfy 2^AW ≥ DEPTH.

Ports:
- clk  in  1  sole clock; everything is sampled on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- in_valid  in  1  a stream byte is present on in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- we  out  1  instruction-memory write strobe, one cycle per word.
- waddr  out  AW  word address of the write.
- wdata  out  32  instruction word being written.
- busy  out  1  a load is in progress (states LEN0, LEN1, DATA).
- done  out  1  the last load completed successfully.
- error  out  1  the last load was rejected.
- cpu_rst  out  1  reset to the core; high in every state except DONE.

## Operation
- States: IDLE, LEN0, LEN1, DATA, DONE, ERR.
- A byte is accepted in a cycle where in_valid && in_ready.
- in_ready is a combinational decode of state. It is 1 in LEN0, LEN1 and DATA, and 0 in all other states.
- The stream never stalls on the write side, so in_ready has no dependence on we.
- IDLE: start moves to LEN0.
- LEN0: the accepted byte goes to len[7:0]; move to LEN1.
- LEN1: the accepted byte goes to len[15:8]. The next state uses the full 16-bit value:
  - len == 0: go to DONE, no write.
  - len > DEPTH: go to ERR.
  - otherwise: go to DATA with byte_cnt = 0 and word_cnt = 0.
- DATA: each accepted byte goes into byte lane byte_cnt, using the order selected under Configuration.
  - byte_cnt is a 2-bit counter that wraps 3→0.
  - On the fourth byte, register we=1, waddr=word_cnt[AW-1:0] and wdata=the assembled word, then increment word_cnt.
  - When the word just completed has index len-1, go to DONE on the same edge.
- DONE: done=1 and cpu_rst=0. start moves to LEN0 for a reload, clearing done and raising cpu_rst on the same edge.
- ERR: error=1 and cpu_rst=1. start moves to LEN0 and clears error.
- start pulses in LEN0, LEN1 or DATA are ignored.
- in_data is ignored whenever in_ready=0.
- The length header is always little-endian, independent of the configuration macro.

## Timing
- Reset values: state=IDLE, in_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, error=0, cpu_rst=1.
- Throughput is one byte per cycle, so a word completes in at least 4 cycles.
- we is registered and asserts for exactly one cycle, on the cycle after the fourth byte of a word is accepted.
- Final word: we=1, done=1 and cpu_rst=0 are all asserted in the same cycle, and the memory captures the word on that cycle's closing edge. The core therefore sees reset released no earlier than the memory write.
- waddr and wdata may hold their last values when we=0.
- rst during a load aborts to IDLE on the next edge:
  - partially assembled bytes are discarded;
  - words already written stay in memory;
  - cpu_rst returns to 1.
- rst takes priority over start and over stream acceptance.

## Configuration
- IMEM_LOADER_BE_EN defined: big-endian assembly. The first byte of each word lands in wdata[31:24] and the fourth in [7:0], matching the assembler's raw .bin output.
- IMEM_LOADER_BE_EN not defined: little-endian assembly. The first byte lands in wdata[7:0] and the fourth in [31:24].

## Test plan
- Little-endian, single word: start, stream 01 00 78 56 34 12 → one we with waddr=0 and wdata=0x12345678; done=1, cpu_rst=0 in the same cycle.
- Big-endian, single word: with IMEM_LOADER_BE_EN, the same stream → wdata=0x78563412.
- Zero length: stream 00 00 → DONE with no we; the next start returns to LEN0 and sets cpu_rst=1.
- Oversize length: stream 01 04 (len=1025, DEPTH=1024) → error=1, cpu_rst=1, no we. A following start plus a valid stream completes normally.
- Maximum length with bubbles: len=1024 with in_valid toggled randomly → 1024 writes at waddr 0..1023 in order, the last one with done=1; no byte lost or duplicated.
- Reset mid-load: rst after 6 data bytes (1 word written) → IDLE and cpu_rst=1 with no further we. A new start plus a 1-word stream writes waddr=0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if #(
  parameter int unsigned AW = 10
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;

  modport master (output in_valid, in_data, input in_ready, we, waddr, wdata);
  modport slave  (input in_valid, in_data, output in_ready, we, waddr, wdata);
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: 16-bit LE word-count header, then 4 bytes per word.
// IMEM_LOADER_BE_EN selects big-endian word assembly (default little-endian).
module imem_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic          cpu_rst
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, DONE, ERR} state_t;

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_t      state;
  logic [15:0] len;
  logic [15:0] word_cnt;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_q;

  logic        accept_c;
  logic [1:0]  lane_c;
  logic [31:0] word_c;
  logic [15:0] len_full_c;
  logic        last_word_c;

  assign bus.in_ready = (state == LEN0) || (state == LEN1) || (state == DATA);
  assign accept_c     = bus.in_valid && bus.in_ready;
  assign len_full_c   = {bus.in_data, len[7:0]};
  assign last_word_c  = (17'(word_cnt) + 17'd1) == 17'(len);

`ifdef IMEM_LOADER_BE_EN
  assign lane_c = 2'd3 - byte_cnt;
`else
  assign lane_c = byte_cnt;
`endif

  // Word as it stands once the current byte is merged into its lane.
  always_comb begin
    word_c = asm_q;
    word_c[{lane_c, 3'b000} +: 8] = bus.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      word_cnt  <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      bus.we    <= 1'b0;
      bus.waddr <= '0;
      bus.wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_rst   <= 1'b1;
    end else begin
      bus.we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LEN0;
            busy  <= 1'b1;
          end
        end
        LEN0: begin
          if (accept_c) begin
            len[7:0] <= bus.in_data;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (accept_c) begin
            len[15:8] <= bus.in_data;
            if (len_full_c == 16'd0) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              cpu_rst <= 1'b0;
            end else if ({1'b0, len_full_c} > DEPTH_W) begin
              state <= ERR;
              busy  <= 1'b0;
              error <= 1'b1;
            end else begin
              state    <= DATA;
              byte_cnt <= '0;
              word_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (accept_c) begin
            asm_q    <= word_c;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.we    <= 1'b1;
              bus.waddr <= word_cnt[AW-1:0];
              bus.wdata <= word_c;
              word_cnt  <= word_cnt + 16'd1;
              // Final write, done and reset release all appear in the same cycle.
              if (last_word_c) begin
                state   <= DONE;
                busy    <= 1'b0;
                done    <= 1'b1;
                cpu_rst <= 1'b0;
              end
            end
          end
        end
        DONE: begin
          if (start) begin
            state   <= LEN0;
            busy    <= 1'b1;
            done    <= 1'b0;
            cpu_rst <= 1'b1;
          end
        end
        ERR: begin
          if (start) begin
            state <= LEN0;
            busy  <= 1'b1;
            error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
